// File: rtl/vga_text_writer_if.sv
// vga_text_writer_if
// Groups the command handshake and the character-buffer write port of the
// text writer into one bundle.
//   cmd_valid / cmd_ready : command handshake (accept when both are 1)
//   cmd_op                : 00 HEX32, 01 CHAR, 10 CLEAR, 11 reserved
//   cmd_row / cmd_col     : target cell coordinates
//   cmd_data              : HEX32 value, or ASCII code in bits [7:0]
//   wen / w_addr / w_data : one byte written to the buffer per wen cycle
// master: the command source, which also observes the write port.
// slave : the text writer itself.
interface vga_text_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_row;
    logic [6:0]  cmd_col;
    logic [31:0] cmd_data;
    logic        wen;
    logic [11:0] w_addr;
    logic [7:0]  w_data;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
        input  cmd_ready, wen, w_addr, w_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data,
        output cmd_ready, wen, w_addr, w_data
    );
endinterface

// File: rtl/vga_text_writer.sv
// vga_text_writer
// Turns high-level text commands into sequential single-byte writes into the
// COLS x ROWS character buffer: print a 32-bit value as 8 uppercase hex
// digits, put one ASCII character, or clear the whole screen to spaces.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : vga_text_writer_if.slave (command handshake + buffer write port)
// All write-port outputs are registered; w_addr/w_data hold while wen is low.
module vga_text_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic               clk,
    input  logic               rst,
    vga_text_writer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, HEX, CHAR, CLEAR} state_t;

    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
    localparam logic [5:0]  ROW_LIM   = 6'(ROWS);
    localparam logic [7:0]  COL_LIM   = 8'(COLS);

    state_t      state, state_next;
    logic        wen_q, wen_next;
    logic [11:0] addr_q, addr_next;
    logic [7:0]  data_q, data_next;
    logic [31:0] shift_q, shift_next;
    logic [3:0]  count_q, count_next;

    logic [11:0] base_addr;
    logic [11:0] addr_inc;
    logic        coords_ok;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    assign base_addr = 12'(bus.cmd_row) * 12'(COLS) + 12'(bus.cmd_col);
    assign coords_ok = ({1'b0, bus.cmd_row} < ROW_LIM) && ({1'b0, bus.cmd_col} < COL_LIM);

    // The buffer is treated as one linear ring, so the last cell steps to 0.
    assign addr_inc = (addr_q == LAST_ADDR) ? 12'd0 : addr_q + 12'd1;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.wen       = wen_q;
    assign bus.w_addr    = addr_q;
    assign bus.w_data    = data_q;

    // State and write-port registers. Reset clears wen at once, abandoning
    // any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= 12'd0;
            data_q  <= 8'd0;
            shift_q <= 32'd0;
            count_q <= 4'd0;
        end else begin
            state   <= state_next;
            wen_q   <= wen_next;
            addr_q  <= addr_next;
            data_q  <= data_next;
            shift_q <= shift_next;
            count_q <= count_next;
        end
    end

    // Next-state and next-output logic. The first write of every command is
    // issued on the accepting edge so wen rises in the very next cycle; HEX
    // keeps the remaining nibbles in a left-shifting register and counts the
    // writes already issued.
    always_comb begin
        state_next = state;
        wen_next   = 1'b0;
        addr_next  = addr_q;
        data_next  = data_q;
        shift_next = shift_q;
        count_next = count_q;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        2'b00: begin
                            if (coords_ok) begin
                                state_next = HEX;
                                wen_next   = 1'b1;
                                addr_next  = base_addr;
                                data_next  = hex_ascii(bus.cmd_data[31:28]);
                                shift_next = {bus.cmd_data[27:0], 4'h0};
                                count_next = 4'd1;
                            end
                        end
                        2'b01: begin
                            if (coords_ok) begin
                                state_next = CHAR;
                                wen_next   = 1'b1;
                                addr_next  = base_addr;
                                data_next  = bus.cmd_data[7:0];
                            end
                        end
                        2'b10: begin
                            state_next = CLEAR;
                            wen_next   = 1'b1;
                            addr_next  = 12'd0;
                            data_next  = 8'h20;
                        end
                        default: begin
                            state_next = IDLE;
                        end
                    endcase
                end
            end
            HEX: begin
                if (count_q == 4'd8) begin
                    state_next = IDLE;
                end else begin
                    wen_next   = 1'b1;
                    addr_next  = addr_inc;
                    data_next  = hex_ascii(shift_q[31:28]);
                    shift_next = {shift_q[27:0], 4'h0};
                    count_next = count_q + 4'd1;
                end
            end
            CHAR: begin
                state_next = IDLE;
            end
            CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    wen_next  = 1'b1;
                    addr_next = addr_inc;
                    data_next = 8'h20;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer
// Scoreboard bench for vga_text_writer: stimulus pushes hand-computed
// expected (address, byte) pairs into a queue, and a monitor on the falling
// clock edge pops and compares one entry for every cycle the DUT asserts wen.
module tb_vga_text_writer;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } write_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_text_writer_if bus();

    vga_text_writer #(.COLS(80), .ROWS(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    write_t exp_q[$];
    int     write_cycles[$];
    int     cycle = 0;
    bit     ignore_writes = 1'b0;
    bit     record_cycles = 1'b0;
    int     checks = 0;
    int     passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Free-running cycle index used to measure gaps between write bursts.
    always @(negedge clk) begin
        cycle <= cycle + 1;
    end

    // Monitor: every write the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.wen === 1'b1 && !ignore_writes) begin
            if (record_cycles) begin
                write_cycles.push_back(cycle);
            end
            checkOutput("write expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                write_t e;
                e = exp_q.pop_front();
                checkOutput($sformatf("w_addr for 0x%0h", e.addr), 32'(bus.w_addr), 32'(e.addr));
                checkOutput($sformatf("w_data at 0x%0h", e.addr), 32'(bus.w_data), 32'(e.data));
            end
        end
    end

    // Queue 8 hex-digit writes from a hand-written character string.
    task automatic expectHex(input logic [11:0] start, input string s);
        logic [11:0] a;
        a = start;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(write_t'{a, s[i]});
            a = (a == 12'd2399) ? 12'd0 : a + 12'd1;
        end
    endtask

    task automatic setCommand(input logic [1:0] op, input logic [4:0] row,
                              input logic [6:0] col, input logic [31:0] data);
        bus.cmd_op   = op;
        bus.cmd_row  = row;
        bus.cmd_col  = col;
        bus.cmd_data = data;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (bus.cmd_ready !== 1'b1) begin
            checkOutput("cmd_ready timeout", 32'(bus.cmd_ready), 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] row,
                                 input logic [6:0] col, input logic [31:0] data);
        waitReady();
        setCommand(op, row, col, data);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count cycles with cmd_ready low after an accept, then confirm every
    // expected write of that command was seen.
    task automatic measureBusy(input string name, input int expected);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checkOutput({name, " busy cycles"}, 32'(n), 32'(expected));
        checkOutput({name, " writes drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int offs[17];
        offs = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 12, 13, 14, 15, 16, 17, 18};

        bus.cmd_valid = 1'b0;
        setCommand(2'b00, 5'd0, 7'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset wen", 32'(bus.wen), 32'd0);
        checkOutput("reset w_addr", 32'(bus.w_addr), 32'd0);
        checkOutput("reset w_data", 32'(bus.w_data), 32'd0);
        rst = 1'b0;

        expectHex(12'd170, "1234ABCD");
        applyStimulus(2'b00, 5'd2, 7'd10, 32'h1234ABCD);
        measureBusy("hex basic", 8);

        expectHex(12'd2396, "DEADBEEF");
        applyStimulus(2'b00, 5'd29, 7'd76, 32'hDEADBEEF);
        measureBusy("hex end wrap", 8);

        expectHex(12'd78, "76543210");
        applyStimulus(2'b00, 5'd0, 7'd78, 32'h76543210);
        measureBusy("hex row wrap", 8);

        exp_q.push_back(write_t'{12'd2399, 8'h41});
        applyStimulus(2'b01, 5'd29, 7'd79, 32'h0000_0041);
        measureBusy("char last cell", 1);

        applyStimulus(2'b01, 5'd30, 7'd0, 32'h0000_0042);
        measureBusy("char bad row", 0);

        applyStimulus(2'b00, 5'd3, 7'd80, 32'hCAFE_F00D);
        measureBusy("hex bad col", 0);

        applyStimulus(2'b11, 5'd1, 7'd1, 32'h0000_0043);
        measureBusy("reserved op", 0);

        for (int i = 0; i < 2400; i++) begin
            exp_q.push_back(write_t'{12'(i), 8'h20});
        end
        applyStimulus(2'b10, 5'd0, 7'd0, 32'd0);
        measureBusy("clear", 2400);

        // Back-to-back: cmd_valid held high across HEX, CHAR, HEX.
        expectHex(12'd80, "00C0FFEE");
        exp_q.push_back(write_t'{12'd245, 8'h5A});
        expectHex(12'd390, "89ABCDEF");
        write_cycles.delete();
        record_cycles = 1'b1;
        waitReady();
        setCommand(2'b00, 5'd1, 7'd0, 32'h00C0FFEE);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        setCommand(2'b01, 5'd3, 7'd5, 32'h0000_005A);
        waitReady();
        @(posedge clk);
        #1;
        setCommand(2'b00, 5'd4, 7'd70, 32'h89ABCDEF);
        waitReady();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        measureBusy("back-to-back", 8);
        record_cycles = 1'b0;
        checkOutput("b2b write count", 32'(write_cycles.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < write_cycles.size()) begin
                checkOutput($sformatf("b2b offset %0d", i),
                            32'(write_cycles[i] - write_cycles[0]), 32'(offs[i]));
            end
        end

        // Reset in the middle of a CLEAR must drop wen without a clock edge.
        ignore_writes = 1'b1;
        applyStimulus(2'b10, 5'd0, 7'd0, 32'd0);
        repeat (50) @(negedge clk);
        checkOutput("clear running", 32'(bus.wen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async wen drop", 32'(bus.wen), 32'd0);
        checkOutput("async w_addr clear", 32'(bus.w_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after reset", 32'(bus.cmd_ready), 32'd1);
        checkOutput("wen after reset", 32'(bus.wen), 32'd0);
        ignore_writes = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("final queue empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
